// File: rtl/alu181_seq_if.sv
// alu181_seq_if: start/done handshake, operands and result/flag bus between
// the control unit (master) and the nibble-serial ALU sequencer (slave).
interface alu181_seq_if #(
    parameter int unsigned NIB = 2
);
    localparam int unsigned W = 4 * NIB;

    logic           start;
    logic [W-1:0]   op_a;
    logic [W-1:0]   op_b;
    logic [3:0]     op_s;
    logic           op_m;
    logic           op_cn;
    logic           busy;
    logic           done;
    logic [W-1:0]   result;
    logic           cout_n;
    logic           zero;
    logic           all_ones;

    modport master (
        output start, op_a, op_b, op_s, op_m, op_cn,
        input  busy, done, result, cout_n, zero, all_ones
    );

    modport slave (
        input  start, op_a, op_b, op_s, op_m, op_cn,
        output busy, done, result, cout_n, zero, all_ones
    );
endinterface

// File: rtl/alu181_seq.sv
// alu181_seq: runs a 4*NIB-bit operation through one shared 4-bit ALU181 slice,
// one nibble per clock, LSB nibble first, chaining C4 back into C0.
module alu181_seq #(
    parameter int unsigned NIB = 2
) (
    input  logic            clk,
    input  logic            rst,
    alu181_seq_if.slave     bus,
    output logic [3:0]      alu_a,
    output logic [3:0]      alu_b,
    output logic [3:0]      alu_s,
    output logic            alu_m,
    output logic            alu_c0,
    input  logic [3:0]      alu_f,
    input  logic            alu_c4,
    input  logic            alu_aeqb
);
    localparam int unsigned W = 4 * NIB;

    typedef enum logic [1:0] {StIdle, StRun, StDone} stateT;

    stateT          stateQ;
    logic [2:0]     nibQ;
    logic [W-1:0]   aQ;
    logic [W-1:0]   bQ;
    logic [W-1:0]   resultQ;
    logic [W-1:0]   resultNext;
    logic           accQ;
    logic           busyQ;
    logic           doneQ;
    logic           coutNQ;
    logic           zeroQ;
    logic           allOnesQ;
    logic           lastNib;

    assign lastNib = (nibQ == 3'(NIB - 1));

    assign bus.busy     = busyQ;
    assign bus.done     = doneQ;
    assign bus.result   = resultQ;
    assign bus.cout_n   = coutNQ;
    assign bus.zero     = zeroQ;
    assign bus.all_ones = allOnesQ;

    // Result with the current slice output merged in, so flags see the final value.
    always_comb begin
        resultNext = resultQ;
        resultNext[4 * nibQ +: 4] = alu_f;
    end

    // Sequencer FSM; aQ/bQ hold the not-yet-issued nibbles, alu_c0 is the carry register.
    always_ff @(posedge clk) begin
        if (rst) begin
            stateQ   <= StIdle;
            nibQ     <= '0;
            aQ       <= '0;
            bQ       <= '0;
            resultQ  <= '0;
            accQ     <= 1'b0;
            busyQ    <= 1'b0;
            doneQ    <= 1'b0;
            coutNQ   <= 1'b1;
            zeroQ    <= 1'b0;
            allOnesQ <= 1'b0;
            alu_a    <= '0;
            alu_b    <= '0;
            alu_s    <= '0;
            alu_m    <= 1'b0;
            alu_c0   <= 1'b1;
        end else begin
            doneQ <= 1'b0;
            case (stateQ)
                StIdle: begin
                    if (bus.start) begin
                        stateQ   <= StRun;
                        busyQ    <= 1'b1;
                        nibQ     <= '0;
                        alu_a    <= bus.op_a[3:0];
                        alu_b    <= bus.op_b[3:0];
                        aQ       <= bus.op_a >> 4;
                        bQ       <= bus.op_b >> 4;
                        alu_s    <= bus.op_s;
                        alu_m    <= bus.op_m;
                        alu_c0   <= bus.op_cn;
                        resultQ  <= '0;
                        accQ     <= 1'b1;
                        coutNQ   <= 1'b1;
                        zeroQ    <= 1'b0;
                        allOnesQ <= 1'b0;
                    end
                end
                StRun: begin
                    resultQ <= resultNext;
                    accQ    <= accQ & alu_aeqb;
                    if (lastNib) begin
                        stateQ   <= StDone;
                        doneQ    <= 1'b1;
                        // Logic mode has no meaningful carry; report "no carry".
                        coutNQ   <= alu_m | alu_c4;
                        zeroQ    <= (resultNext == '0);
                        allOnesQ <= accQ & alu_aeqb;
                    end else begin
                        nibQ   <= nibQ + 3'd1;
                        alu_a  <= aQ[3:0];
                        alu_b  <= bQ[3:0];
                        aQ     <= aQ >> 4;
                        bQ     <= bQ >> 4;
                        // Active-low carry passes straight through, no inversion.
                        alu_c0 <= alu_c4;
                    end
                end
                StDone: begin
                    stateQ <= StIdle;
                    busyQ  <= 1'b0;
                end
                default: stateQ <= StIdle;
            endcase
        end
    end
endmodule

// File: tb/tb_alu181_seq.sv
// tb_alu181_seq: directed vectors with a scoreboard queue; a negedge monitor
// pops the expected response whenever done is presented.
module tb_alu181_seq;
    localparam int unsigned NIB = 2;
    localparam int unsigned W   = 4 * NIB;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    alu181_seq_if #(.NIB(NIB)) bus ();

    logic [3:0] alu_a, alu_b, alu_s, alu_f;
    logic       alu_m, alu_c0, alu_c4, alu_aeqb;

    alu181_seq #(.NIB(NIB)) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .alu_a    (alu_a),
        .alu_b    (alu_b),
        .alu_s    (alu_s),
        .alu_m    (alu_m),
        .alu_c0   (alu_c0),
        .alu_f    (alu_f),
        .alu_c4   (alu_c4),
        .alu_aeqb (alu_aeqb)
    );

    // 74181 slice model, active-high data, active-low carries.
    logic [3:0] t1, t2;
    logic [4:0] sum;
    always_comb begin
        t1 = alu_a | (alu_b & {4{alu_s[0]}}) | (~alu_b & {4{alu_s[1]}});
        t2 = (alu_a & ~alu_b & {4{alu_s[2]}}) | (alu_a & alu_b & {4{alu_s[3]}});
        sum = {1'b0, t1} + {1'b0, t2} + {4'b0, ~alu_c0};
        alu_f = alu_m ? ~(t1 ^ t2) : sum[3:0];
        alu_c4 = ~sum[4];
        alu_aeqb = (alu_f == 4'hF);
    end

    typedef struct packed {
        logic [W-1:0] result;
        logic         coutN;
        logic         zero;
        logic         allOnes;
    } expT;

    expT expQ[$];
    expT mon;
    int  nChecks = 0;
    int  nFails  = 0;
    int  nDone   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (bus.done) begin
            nDone++;
            if (expQ.size() == 0) begin
                nChecks++;
                nFails++;
                $display("FAIL unexpected_done: got done with result 0x%0h, expected no done",
                         bus.result);
            end else begin
                mon = expQ.pop_front();
                check("mon_result", 32'(bus.result), 32'(mon.result));
                check("mon_cout_n", 32'(bus.cout_n), 32'(mon.coutN));
                check("mon_zero", 32'(bus.zero), 32'(mon.zero));
                check("mon_all_ones", 32'(bus.all_ones), 32'(mon.allOnes));
                check("mon_busy", 32'(bus.busy), 32'd1);
            end
        end
    end

    task automatic runOp(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [3:0] s, input logic m, input logic cn,
                         input logic [W-1:0] r, input logic co, input logic z,
                         input logic ao);
        int n;
        @(negedge clk);
        bus.op_a  = a;
        bus.op_b  = b;
        bus.op_s  = s;
        bus.op_m  = m;
        bus.op_cn = cn;
        bus.start = 1'b1;
        expQ.push_back(expT'{r, co, z, ao});
        @(posedge clk);
        #1 bus.start = 1'b0;
        check({name, "_busy"}, 32'(bus.busy), 32'd1);
        n = 0;
        while (!bus.done && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        check({name, "_latency"}, 32'(n), 32'(NIB));
        @(posedge clk);
        #1;
        check({name, "_idle"}, 32'(bus.busy), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        int doneBefore;
        rst       = 1'b1;
        bus.start = 1'b0;
        bus.op_a  = '0;
        bus.op_b  = '0;
        bus.op_s  = '0;
        bus.op_m  = 1'b0;
        bus.op_cn = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_result", 32'(bus.result), 32'd0);
        check("rst_cout_n", 32'(bus.cout_n), 32'd1);
        check("rst_zero", 32'(bus.zero), 32'd0);
        check("rst_all_ones", 32'(bus.all_ones), 32'd0);
        check("rst_alu_c0", 32'(alu_c0), 32'd1);
        check("rst_alu_a", 32'(alu_a), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // A plus B, then a carry out of the top nibble.
        runOp("add1", 8'h35, 8'h17, 4'b1001, 1'b0, 1'b1, 8'h4C, 1'b1, 1'b0, 1'b0);
        runOp("add2", 8'hF0, 8'h20, 4'b1001, 1'b0, 1'b1, 8'h10, 1'b0, 1'b0, 1'b0);
        // A minus B: no borrow, then borrow producing all ones.
        runOp("sub1", 8'h50, 8'h21, 4'b0110, 1'b0, 1'b0, 8'h2F, 1'b0, 1'b0, 1'b0);
        runOp("sub2", 8'h00, 8'h01, 4'b0110, 1'b0, 1'b0, 8'hFF, 1'b1, 1'b0, 1'b1);
        // Logic XOR, then an all-zero result.
        runOp("xor1", 8'hA5, 8'h0F, 4'b0110, 1'b1, 1'b1, 8'hAA, 1'b1, 1'b0, 1'b0);
        runOp("xor2", 8'h3C, 8'h3C, 4'b0110, 1'b1, 1'b1, 8'h00, 1'b1, 1'b1, 1'b0);

        // start held every cycle, including the done cycle; garbage operands after accept.
        doneBefore = nDone;
        @(negedge clk);
        bus.op_a  = 8'h35;
        bus.op_b  = 8'h17;
        bus.op_s  = 4'b1001;
        bus.op_m  = 1'b0;
        bus.op_cn = 1'b1;
        bus.start = 1'b1;
        expQ.push_back(expT'{8'h4C, 1'b1, 1'b0, 1'b0});
        @(posedge clk);
        n = 0;
        while (n < 20) begin
            @(negedge clk);
            bus.op_a = 8'hFF;
            bus.op_b = 8'hFF;
            bus.op_s = 4'b0000;
            bus.op_m = 1'b1;
            if (bus.done) break;
            n++;
        end
        check("spam_done_seen", 32'(n < 20), 32'd1);
        @(negedge clk);
        bus.start = 1'b0;
        repeat (4) @(negedge clk);
        check("spam_idle", 32'(bus.busy), 32'd0);
        check("spam_one_done", 32'(nDone - doneBefore), 32'd1);

        // Reset during nibble 1 discards the operation.
        doneBefore = nDone;
        @(negedge clk);
        bus.op_a  = 8'h35;
        bus.op_b  = 8'h17;
        bus.op_s  = 4'b1001;
        bus.op_m  = 1'b0;
        bus.op_cn = 1'b1;
        bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        check("mrst_busy", 32'(bus.busy), 32'd0);
        check("mrst_result", 32'(bus.result), 32'd0);
        check("mrst_cout_n", 32'(bus.cout_n), 32'd1);
        check("mrst_done", 32'(bus.done), 32'd0);
        repeat (5) @(posedge clk);
        #1;
        check("mrst_no_done", 32'(nDone - doneBefore), 32'd0);

        runOp("post_rst", 8'hF0, 8'h20, 4'b1001, 1'b0, 1'b1, 8'h10, 1'b0, 1'b0, 1'b0);

        repeat (3) @(posedge clk);
        check("queue_empty", 32'(expQ.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end
endmodule
